// File: rtl/rocc_cmd_router_if.sv
// Bundle of the core-side RoCC port and the per-accelerator fan-out/fan-in signals.
// The slave modport is the router's view; master is the surrounding tile/bench view.
interface rocc_cmd_router_if #(
  parameter int XLEN    = 64,
  parameter int NUM_ACC = 2
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [6:0]              cmd_funct;
  logic [4:0]              cmd_rd;
  logic                    cmd_xd;
  logic [6:0]              cmd_opcode;
  logic [XLEN-1:0]         cmd_rs1;
  logic [XLEN-1:0]         cmd_rs2;

  logic [NUM_ACC-1:0]      acc_cmd_valid;
  logic [NUM_ACC-1:0]      acc_cmd_ready;
  logic [6:0]              acc_cmd_funct;
  logic [4:0]              acc_cmd_rd;
  logic                    acc_cmd_xd;
  logic [XLEN-1:0]         acc_cmd_rs1;
  logic [XLEN-1:0]         acc_cmd_rs2;

  logic [NUM_ACC-1:0]      acc_resp_valid;
  logic [NUM_ACC-1:0]      acc_resp_ready;
  logic [5*NUM_ACC-1:0]    acc_resp_rd;
  logic [XLEN*NUM_ACC-1:0] acc_resp_data;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [4:0]              resp_rd;
  logic [XLEN-1:0]         resp_data;

  logic [NUM_ACC-1:0]      acc_busy;
  logic [NUM_ACC-1:0]      acc_interrupt;
  logic                    busy;
  logic                    interrupt;
  logic                    err_unmapped;
  logic                    err_spurious;

  modport slave (
    input  cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_opcode, cmd_rs1, cmd_rs2,
    output cmd_ready,
    output acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    input  acc_cmd_ready,
    input  acc_resp_valid, acc_resp_rd, acc_resp_data,
    output acc_resp_ready,
    output resp_valid, resp_rd, resp_data,
    input  resp_ready,
    input  acc_busy, acc_interrupt,
    output busy, interrupt, err_unmapped, err_spurious
  );

  modport master (
    output cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_opcode, cmd_rs1, cmd_rs2,
    input  cmd_ready,
    input  acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    output acc_cmd_ready,
    output acc_resp_valid, acc_resp_rd, acc_resp_data,
    input  acc_resp_ready,
    input  resp_valid, resp_rd, resp_data,
    output resp_ready,
    output acc_busy, acc_interrupt,
    input  busy, interrupt, err_unmapped, err_spurious
  );
endinterface

// File: rtl/rocc_cmd_router.sv
// Shares one RoCC port between NUM_ACC accelerators: opcode-slot command steering,
// round-robin response merge, outstanding counters. Define ROCC_ROUTER_PERF_EN for perf counters.
module rocc_cmd_router #(
  parameter int XLEN            = 64,
  parameter int NUM_ACC         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clock,
  input  logic             reset,
  rocc_cmd_router_if.slave bus
`ifdef ROCC_ROUTER_PERF_EN
  ,
  output logic [31:0]      perf_cmd_count,
  output logic [31:0]      perf_resp_count,
  output logic [31:0]      perf_stall_cycles
`endif
);

  logic [1:0]         sel;
  logic               mapped;
  logic               cmd_ready_c;
  logic               cmd_fire;
  logic [NUM_ACC-1:0] acc_cmd_valid_c;
  logic [NUM_ACC-1:0] full;
  logic [NUM_ACC-1:0] nonzero;
  logic [NUM_ACC-1:0] inc;
  logic [NUM_ACC-1:0] dec;
  logic [3:0]         cnt [NUM_ACC];

  logic [1:0]         ptr;
  logic               load_en;
  logic               grant_valid;
  int                 grant_idx;
  logic [4:0]         grant_rd;
  logic [XLEN-1:0]    grant_data;
  logic [NUM_ACC-1:0] acc_resp_ready_c;

  logic               resp_valid_q;
  logic [4:0]         resp_rd_q;
  logic [XLEN-1:0]    resp_data_q;
  logic               err_unmapped_q;
  logic               err_spurious_q;

  assign sel      = bus.cmd_opcode[6:5];
  assign mapped   = ({1'b0, sel} < 3'(NUM_ACC));
  assign cmd_fire = bus.cmd_valid & cmd_ready_c;
  assign load_en  = ~resp_valid_q | bus.resp_ready;

  // Unmapped slots are always ready so the core never deadlocks on a bad opcode.
  always_comb begin
    cmd_ready_c     = 1'b1;
    acc_cmd_valid_c = '0;
    full            = '0;
    nonzero         = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      full[i]    = (cnt[i] == 4'(MAX_OUTSTANDING));
      nonzero[i] = (cnt[i] != 4'd0);
      if (int'(sel) == i) begin
        acc_cmd_valid_c[i] = bus.cmd_valid & ~full[i];
        cmd_ready_c        = bus.acc_cmd_ready[i] & ~full[i];
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      inc[i] = cmd_fire & bus.cmd_xd & (int'(sel) == i);
    end
  end

  // Priority is distance from ptr: candidate k steps after ptr wins over k+1.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 0;
    for (int k = 0; k < NUM_ACC; k++) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (!grant_valid && bus.acc_resp_valid[i] && (((int'(ptr) + k) % NUM_ACC) == i)) begin
          grant_valid = 1'b1;
          grant_idx   = i;
        end
      end
    end
  end

  always_comb begin
    acc_resp_ready_c = '0;
    grant_rd         = '0;
    grant_data       = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (grant_idx == i) begin
        grant_rd            = bus.acc_resp_rd[5*i +: 5];
        grant_data          = bus.acc_resp_data[XLEN*i +: XLEN];
        acc_resp_ready_c[i] = load_en & grant_valid;
      end
    end
  end

  assign dec = bus.acc_resp_valid & acc_resp_ready_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        cnt[i] <= 4'd0;
      end
      ptr            <= 2'd0;
      resp_valid_q   <= 1'b0;
      resp_rd_q      <= '0;
      resp_data_q    <= '0;
      err_unmapped_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        case ({inc[i], dec[i]})
          2'b10:   cnt[i] <= cnt[i] + 4'd1;
          2'b01:   if (nonzero[i]) cnt[i] <= cnt[i] - 4'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (cmd_fire && !mapped) begin
        err_unmapped_q <= 1'b1;
      end
      if (|(dec & ~nonzero)) begin
        err_spurious_q <= 1'b1;
      end
      if (load_en) begin
        if (grant_valid) begin
          resp_valid_q <= 1'b1;
          resp_rd_q    <= grant_rd;
          resp_data_q  <= grant_data;
          ptr          <= 2'((grant_idx + 1) % NUM_ACC);
        end else begin
          resp_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready      = cmd_ready_c;
  assign bus.acc_cmd_valid  = acc_cmd_valid_c;
  assign bus.acc_cmd_funct  = bus.cmd_funct;
  assign bus.acc_cmd_rd     = bus.cmd_rd;
  assign bus.acc_cmd_xd     = bus.cmd_xd;
  assign bus.acc_cmd_rs1    = bus.cmd_rs1;
  assign bus.acc_cmd_rs2    = bus.cmd_rs2;
  assign bus.acc_resp_ready = acc_resp_ready_c;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rd        = resp_rd_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.busy           = (|bus.acc_busy) | (|nonzero) | resp_valid_q;
  assign bus.interrupt      = |bus.acc_interrupt;
  assign bus.err_unmapped   = err_unmapped_q;
  assign bus.err_spurious   = err_spurious_q;

`ifdef ROCC_ROUTER_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cmd_count    <= 32'd0;
      perf_resp_count   <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (cmd_fire) perf_cmd_count <= perf_cmd_count + 32'd1;
      if (resp_valid_q && bus.resp_ready) perf_resp_count <= perf_resp_count + 32'd1;
      if (bus.cmd_valid && !cmd_ready_c) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rocc_cmd_router.sv
// Directed plus randomized bench for rocc_cmd_router against a transaction-level model
// of outstanding counts, the held response and the round-robin pointer.
module tb_rocc_cmd_router;
  localparam int XLEN = 64;
  localparam int NA   = 2;
  localparam int MAXO = 4;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rocc_cmd_router_if #(.XLEN(XLEN), .NUM_ACC(NA)) bus ();

`ifdef ROCC_ROUTER_PERF_EN
  logic [31:0] perf_cmd_count;
  logic [31:0] perf_resp_count;
  logic [31:0] perf_stall_cycles;
`endif

  rocc_cmd_router #(.XLEN(XLEN), .NUM_ACC(NA), .MAX_OUTSTANDING(MAXO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ROCC_ROUTER_PERF_EN
    ,
    .perf_cmd_count    (perf_cmd_count),
    .perf_resp_count   (perf_resp_count),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int              m_cnt [NA];
  bit              m_rv;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  int              m_ptr;
  bit              m_eu;
  bit              m_es;
  logic [31:0]     m_pc;
  logic [31:0]     m_pr;
  logic [31:0]     m_ps;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    reset              = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_funct      = 7'd0;
    bus.cmd_rd         = 5'd0;
    bus.cmd_xd         = 1'b0;
    bus.cmd_opcode     = 7'h0B;
    bus.cmd_rs1        = '0;
    bus.cmd_rs2        = '0;
    bus.acc_cmd_ready  = '0;
    bus.acc_resp_valid = '0;
    bus.acc_resp_rd    = '0;
    bus.acc_resp_data  = '0;
    bus.resp_ready     = 1'b1;
    bus.acc_busy       = '0;
    bus.acc_interrupt  = '0;
  endtask

  // One clock: check every output against the model at the falling edge, then advance the model.
  task automatic applyStimulus();
    int          sel;
    int          g;
    int          idx;
    bit          mapped;
    bit          load;
    bit          fire;
    bit          incr;
    bit          decr;
    bit          any_cnt;
    bit          e_cr;
    logic [NA-1:0] e_acv;
    logic [NA-1:0] e_arr;
    @(negedge clock);
    sel    = int'(bus.cmd_opcode[6:5]);
    mapped = (sel < NA);
    e_acv  = '0;
    for (int i = 0; i < NA; i++) e_acv[i] = bus.cmd_valid && (sel == i) && (m_cnt[i] < MAXO);
    e_cr = mapped ? (bus.acc_cmd_ready[sel] && (m_cnt[sel] < MAXO)) : 1'b1;
    load = !m_rv || bus.resp_ready;
    g = -1;
    for (int k = 0; k < NA; k++) begin
      idx = (m_ptr + k) % NA;
      if (g < 0 && bus.acc_resp_valid[idx]) g = idx;
    end
    e_arr = '0;
    if (load && g >= 0) e_arr[g] = 1'b1;
    any_cnt = 1'b0;
    for (int i = 0; i < NA; i++) if (m_cnt[i] != 0) any_cnt = 1'b1;

    checkOutput("cmd_ready", bus.cmd_ready, e_cr);
    checkOutput("acc_cmd_valid", bus.acc_cmd_valid, e_acv);
    checkOutput("acc_cmd_fields", {bus.acc_cmd_funct, bus.acc_cmd_rd, bus.acc_cmd_xd},
                {bus.cmd_funct, bus.cmd_rd, bus.cmd_xd});
    checkOutput("acc_cmd_rs1", bus.acc_cmd_rs1, bus.cmd_rs1);
    checkOutput("acc_cmd_rs2", bus.acc_cmd_rs2, bus.cmd_rs2);
    checkOutput("acc_resp_ready", bus.acc_resp_ready, e_arr);
    checkOutput("resp_valid", bus.resp_valid, m_rv);
    checkOutput("resp_rd", bus.resp_rd, m_rd);
    checkOutput("resp_data", bus.resp_data, m_data);
    checkOutput("busy", bus.busy, (|bus.acc_busy) || any_cnt || m_rv);
    checkOutput("interrupt", bus.interrupt, |bus.acc_interrupt);
    checkOutput("err_unmapped", bus.err_unmapped, m_eu);
    checkOutput("err_spurious", bus.err_spurious, m_es);
`ifdef ROCC_ROUTER_PERF_EN
    checkOutput("perf_cmd_count", perf_cmd_count, m_pc);
    checkOutput("perf_resp_count", perf_resp_count, m_pr);
    checkOutput("perf_stall_cycles", perf_stall_cycles, m_ps);
`endif

    fire = bus.cmd_valid && e_cr;
    if (reset) begin
      for (int i = 0; i < NA; i++) m_cnt[i] = 0;
      m_rv = 1'b0; m_rd = '0; m_data = '0; m_ptr = 0; m_eu = 1'b0; m_es = 1'b0;
      m_pc = '0; m_pr = '0; m_ps = '0;
    end else begin
      if (fire) m_pc = m_pc + 32'd1;
      if (m_rv && bus.resp_ready) m_pr = m_pr + 32'd1;
      if (bus.cmd_valid && !e_cr) m_ps = m_ps + 32'd1;
      if (fire && !mapped) m_eu = 1'b1;
      for (int i = 0; i < NA; i++) begin
        incr = fire && mapped && (sel == i) && bus.cmd_xd;
        decr = (g == i) && load;
        if (decr && m_cnt[i] == 0) m_es = 1'b1;
        if (incr && !decr) m_cnt[i] = m_cnt[i] + 1;
        else if (decr && !incr && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
      if (load) begin
        if (g >= 0) begin
          m_rv   = 1'b1;
          m_rd   = bus.acc_resp_rd[5*g +: 5];
          m_data = bus.acc_resp_data[XLEN*g +: XLEN];
          m_ptr  = (g + 1) % NA;
        end else begin
          m_rv = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int         r;
    logic [1:0] slot;
    for (int i = 0; i < NA; i++) m_cnt[i] = 0;
    m_rv = 1'b0; m_rd = '0; m_data = '0; m_ptr = 0; m_eu = 1'b0; m_es = 1'b0;
    m_pc = '0; m_pr = '0; m_ps = '0;
    setIdle();
    reset = 1'b1;
    @(posedge clock); #1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_resp_rd", bus.resp_rd, 5'd0);
    checkOutput("rst_resp_data", bus.resp_data, 64'd0);
    checkOutput("rst_errs", {bus.err_unmapped, bus.err_spurious}, 2'b00);
    checkOutput("rst_busy", bus.busy, 1'b0);

    $display("[TB] custom1 command and response");
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 7'h2B; bus.cmd_xd = 1'b1;
    bus.cmd_rs1 = 64'd5; bus.acc_cmd_ready = 2'b11;
    #1;
    checkOutput("tp1_acc_cmd_valid", bus.acc_cmd_valid, 2'b10);
    checkOutput("tp1_cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("tp1_rs1", bus.acc_cmd_rs1, 64'd5);
    applyStimulus();
    bus.cmd_valid = 1'b0;
    bus.acc_resp_valid = 2'b10; bus.acc_resp_rd = {5'd3, 5'd0}; bus.acc_resp_data = {64'h10, 64'h0};
    #1;
    checkOutput("tp1_busy_cnt1", bus.busy, 1'b1);
    checkOutput("tp1_grant", bus.acc_resp_ready, 2'b10);
    applyStimulus();
    bus.acc_resp_valid = 2'b00;
    #1;
    checkOutput("tp1_resp_valid", bus.resp_valid, 1'b1);
    checkOutput("tp1_resp_rd", bus.resp_rd, 5'd3);
    checkOutput("tp1_resp_data", bus.resp_data, 64'h10);
    applyStimulus();
    checkOutput("tp1_idle_busy", bus.busy, 1'b0);

    $display("[TB] outstanding limit on acc0");
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 7'h0B; bus.cmd_xd = 1'b1; bus.acc_cmd_ready = 2'b01;
    repeat (4) applyStimulus();
    checkOutput("tp2_full_cmd_ready", bus.cmd_ready, 1'b0);
    checkOutput("tp2_full_acc_cmd_valid", bus.acc_cmd_valid, 2'b00);
    bus.acc_resp_valid = 2'b01; bus.acc_resp_rd = {5'd0, 5'd7}; bus.acc_resp_data = {64'h0, 64'hAA};
    #1;
    checkOutput("tp2_drain_grant", bus.acc_resp_ready, 2'b01);
    checkOutput("tp2_drain_cmd_ready", bus.cmd_ready, 1'b0);
    applyStimulus();
    checkOutput("tp2_cnt3_cmd_ready", bus.cmd_ready, 1'b1);
    applyStimulus();
    bus.acc_resp_valid = 2'b00;
    #1;
    checkOutput("tp2_simul_cmd_ready", bus.cmd_ready, 1'b1);
    applyStimulus();
    checkOutput("tp2_refull_cmd_ready", bus.cmd_ready, 1'b0);
    bus.cmd_valid = 1'b0; bus.acc_resp_valid = 2'b01;
    repeat (4) applyStimulus();
    bus.acc_resp_valid = 2'b00;
    applyStimulus();
    checkOutput("tp2_drained_busy", bus.busy, 1'b0);
    checkOutput("tp2_no_spurious", bus.err_spurious, 1'b0);

    $display("[TB] round robin and stall");
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    bus.acc_resp_valid = 2'b11; bus.acc_resp_rd = {5'd2, 5'd1};
    bus.acc_resp_data = {64'hB1, 64'hA0}; bus.resp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput("tp3_rr_grant", bus.acc_resp_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
      applyStimulus();
    end
    bus.resp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checkOutput("tp3_stall_ready", bus.acc_resp_ready, 2'b00);
      checkOutput("tp3_stall_rd", bus.resp_rd, 5'd2);
      checkOutput("tp3_stall_data", bus.resp_data, 64'hB1);
      applyStimulus();
    end
    bus.resp_ready = 1'b1; bus.acc_resp_valid = 2'b00;
    applyStimulus();

    $display("[TB] unmapped command");
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 7'h5B; bus.cmd_xd = 1'b1;
    #1;
    checkOutput("tp4_cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("tp4_acc_cmd_valid", bus.acc_cmd_valid, 2'b00);
    applyStimulus();
    bus.cmd_valid = 1'b0;
    #1;
    checkOutput("tp4_err_unmapped", bus.err_unmapped, 1'b1);
    repeat (3) applyStimulus();
    checkOutput("tp4_sticky", bus.err_unmapped, 1'b1);
    checkOutput("tp4_no_resp", bus.resp_valid, 1'b0);
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    #1;
    checkOutput("tp4_cleared", bus.err_unmapped, 1'b0);

    $display("[TB] spurious response");
    bus.acc_resp_valid = 2'b01; bus.acc_resp_rd = {5'd0, 5'd9}; bus.acc_resp_data = {64'h0, 64'h55};
    applyStimulus();
    bus.acc_resp_valid = 2'b00;
    #1;
    checkOutput("tp5_err_spurious", bus.err_spurious, 1'b1);
    checkOutput("tp5_fwd_valid", bus.resp_valid, 1'b1);
    checkOutput("tp5_fwd_rd", bus.resp_rd, 5'd9);
    applyStimulus();
    checkOutput("tp5_cnt0_busy", bus.busy, 1'b0);

    $display("[TB] reset mid-operation");
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 7'h0B; bus.cmd_xd = 1'b1; bus.acc_cmd_ready = 2'b11;
    repeat (3) applyStimulus();
    bus.cmd_opcode = 7'h2B;
    applyStimulus();
    bus.cmd_valid = 1'b0; bus.resp_ready = 1'b0; bus.acc_resp_valid = 2'b01;
    applyStimulus();
    bus.acc_resp_valid = 2'b00;
    #1;
    checkOutput("tp6_held_valid", bus.resp_valid, 1'b1);
    checkOutput("tp6_held_busy", bus.busy, 1'b1);
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    #1;
    checkOutput("tp6_rst_valid", bus.resp_valid, 1'b0);
    checkOutput("tp6_rst_busy", bus.busy, 1'b0);
    bus.acc_resp_valid = 2'b11; bus.resp_ready = 1'b1;
    #1;
    checkOutput("tp6_first_grant", bus.acc_resp_ready, 2'b01);
    applyStimulus();
    setIdle();
    applyStimulus();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      slot = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      bus.cmd_opcode     = {slot, 5'b01011};
      bus.cmd_funct      = 7'($urandom);
      bus.cmd_rd         = 5'($urandom);
      bus.cmd_xd         = 1'($urandom_range(0, 1));
      bus.cmd_rs1        = {$urandom, $urandom};
      bus.cmd_rs2        = {$urandom, $urandom};
      bus.acc_cmd_ready  = 2'($urandom);
      bus.acc_resp_valid = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      bus.acc_resp_rd    = 10'($urandom);
      bus.acc_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.resp_ready     = ($urandom_range(0, 3) != 0);
      bus.acc_busy       = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      bus.acc_interrupt  = 2'($urandom);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
